// File: rtl/regfile_sb.sv
// regfile_sb: 2-read/1-write register file with a per-register busy scoreboard.
// Reads are combinational, with an optional same-cycle write bypass and an optional
// hardwired-zero R0. The scoreboard tracks reservations from issue to writeback,
// flags double reservations and reports a registered busy count.
module regfile_sb #(
    parameter int WIDTH   = 8,
    parameter int ADDR_W  = 3,
    parameter int ZERO_R0 = 0,
    parameter int BYPASS  = 1
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [ADDR_W-1:0] SA,
    input  logic [ADDR_W-1:0] SB,
    output logic [WIDTH-1:0]  DataA,
    output logic [WIDTH-1:0]  DataB,
    output logic              BusyA,
    output logic              BusyB,
    input  logic              LD,
    input  logic [ADDR_W-1:0] DR,
    input  logic [WIDTH-1:0]  D_in,
    input  logic              RSV,
    input  logic [ADDR_W-1:0] RSV_DR,
    input  logic              CLR,
    output logic              RSV_ERR,
    output logic [ADDR_W:0]   NBUSY
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0] busy_q, busy_d;
    logic             rsv_err_q, rsv_err_d;
    logic [ADDR_W:0]  nbusy_q, nbusy_d;

    logic ld_ok, rsv_ok, fwd_a, fwd_b, zero_a, zero_b;

    // A write or reservation aimed at a hardwired-zero R0 is dropped
    assign ld_ok  = LD  && !((ZERO_R0 != 0) && (DR == '0));
    assign rsv_ok = RSV && !((ZERO_R0 != 0) && (RSV_DR == '0));

    // Same-cycle writeback to the register being read (bypass build only)
    assign fwd_a  = (BYPASS != 0) && LD && (DR == SA);
    assign fwd_b  = (BYPASS != 0) && LD && (DR == SB);
    assign zero_a = (ZERO_R0 != 0) && (SA == '0);
    assign zero_b = (ZERO_R0 != 0) && (SB == '0);

    // Combinational read ports: zero-R0 first, then forwarded write data, then storage
    always_comb begin
        DataA = regs_q[SA];
        DataB = regs_q[SB];
        if (zero_a)             DataA = '0;
        else if (fwd_a && !CLR) DataA = D_in;
        if (zero_b)             DataB = '0;
        else if (fwd_b && !CLR) DataB = D_in;
        BusyA = fwd_a ? 1'b0 : busy_q[SA];
        BusyB = fwd_b ? 1'b0 : busy_q[SB];
    end

    // Next state: CLR wins over everything, a new reservation wins over a same-index writeback
    always_comb begin
        regs_d    = regs_q;
        busy_d    = busy_q;
        rsv_err_d = 1'b0;
        nbusy_d   = '0;
        if (CLR) begin
            regs_d = '{default: '0};
            busy_d = '0;
        end else begin
            if (ld_ok) begin
                regs_d[DR] = D_in;
                busy_d[DR] = 1'b0;
            end
            if (rsv_ok) begin
                busy_d[RSV_DR] = 1'b1;
            end
            rsv_err_d = RSV && busy_q[RSV_DR] && !(LD && (DR == RSV_DR));
        end
        for (int i = 0; i < DEPTH; i++) begin
            nbusy_d = nbusy_d + {{ADDR_W{1'b0}}, busy_d[i]};
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            regs_q    <= '{default: '0};
            busy_q    <= '0;
            rsv_err_q <= 1'b0;
            nbusy_q   <= '0;
        end else begin
            regs_q    <= regs_d;
            busy_q    <= busy_d;
            rsv_err_q <= rsv_err_d;
            nbusy_q   <= nbusy_d;
        end
    end

    assign RSV_ERR = rsv_err_q;
    assign NBUSY   = nbusy_q;

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: drives two regfile_sb builds in lockstep (default build, and a
// ZERO_R0=1 / BYPASS=0 build) and compares both against an array-based model.
module tb_regfile_sb;

    logic       CLK = 1'b0;
    logic       RESET_N;
    logic [2:0] SA, SB, DR, RSV_DR;
    logic [7:0] D_in;
    logic       LD, RSV, CLR;

    logic [7:0] da [2];
    logic [7:0] db [2];
    logic       ba [2];
    logic       bb [2];
    logic       rerr [2];
    logic [3:0] nb [2];

    int n_checks = 0;
    int n_fail   = 0;

    // model state per instance: 0 = default build, 1 = zero-R0 / no-bypass build
    logic [7:0] m_r    [2][8];
    logic       m_busy [2][8];
    logic       m_err  [2];
    int         m_nb   [2];
    int         zr  [2] = '{0, 1};
    int         byp [2] = '{1, 0};

    always #5 CLK = ~CLK;

    regfile_sb #(.WIDTH(8), .ADDR_W(3), .ZERO_R0(0), .BYPASS(1)) u_dut (
        .CLK(CLK), .RESET_N(RESET_N), .SA(SA), .SB(SB),
        .DataA(da[0]), .DataB(db[0]), .BusyA(ba[0]), .BusyB(bb[0]),
        .LD(LD), .DR(DR), .D_in(D_in), .RSV(RSV), .RSV_DR(RSV_DR), .CLR(CLR),
        .RSV_ERR(rerr[0]), .NBUSY(nb[0])
    );

    regfile_sb #(.WIDTH(8), .ADDR_W(3), .ZERO_R0(1), .BYPASS(0)) u_alt (
        .CLK(CLK), .RESET_N(RESET_N), .SA(SA), .SB(SB),
        .DataA(da[1]), .DataB(db[1]), .BusyA(ba[1]), .BusyB(bb[1]),
        .LD(LD), .DR(DR), .D_in(D_in), .RSV(RSV), .RSV_DR(RSV_DR), .CLR(CLR),
        .RSV_ERR(rerr[1]), .NBUSY(nb[1])
    );

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    task automatic mreset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 8; i++) begin
                m_r[k][i]    = 8'h00;
                m_busy[k][i] = 1'b0;
            end
            m_err[k] = 1'b0;
            m_nb[k]  = 0;
        end
    endtask

    function automatic logic [7:0] exp_data(int k, logic [2:0] a);
        if (zr[k] != 0 && a == 3'd0) return 8'h00;
        if (byp[k] != 0 && LD && DR == a && !CLR) return D_in;
        return m_r[k][a];
    endfunction

    function automatic logic exp_busy(int k, logic [2:0] a);
        if (byp[k] != 0 && LD && DR == a) return 1'b0;
        return m_busy[k][a];
    endfunction

    // clock-edge update of the model from the spec rules
    task automatic mstep();
        for (int k = 0; k < 2; k++) begin
            if (CLR) begin
                for (int i = 0; i < 8; i++) begin
                    m_r[k][i]    = 8'h00;
                    m_busy[k][i] = 1'b0;
                end
                m_err[k] = 1'b0;
            end else begin
                m_err[k] = RSV && m_busy[k][RSV_DR] && !(LD && DR == RSV_DR);
                if (LD && !(zr[k] != 0 && DR == 3'd0)) begin
                    m_r[k][DR]    = D_in;
                    m_busy[k][DR] = 1'b0;
                end
                if (RSV && !(zr[k] != 0 && RSV_DR == 3'd0)) m_busy[k][RSV_DR] = 1'b1;
            end
            m_nb[k] = 0;
            for (int i = 0; i < 8; i++) m_nb[k] += int'(m_busy[k][i]);
        end
    endtask

    task automatic check_comb();
        for (int k = 0; k < 2; k++) begin
            chk("DataA", k, 32'(da[k]), 32'(exp_data(k, SA)));
            chk("DataB", k, 32'(db[k]), 32'(exp_data(k, SB)));
            chk("BusyA", k, 32'(ba[k]), 32'(exp_busy(k, SA)));
            chk("BusyB", k, 32'(bb[k]), 32'(exp_busy(k, SB)));
        end
    endtask

    task automatic check_reg();
        for (int k = 0; k < 2; k++) begin
            chk("RSV_ERR", k, 32'(rerr[k]), 32'(m_err[k]));
            chk("NBUSY", k, 32'(nb[k]), 32'(m_nb[k]));
        end
    endtask

    task automatic cycle(input logic ld, input logic [2:0] dr, input logic [7:0] din,
                         input logic rsv, input logic [2:0] rdr, input logic clr,
                         input logic [2:0] sa, input logic [2:0] sb);
        @(negedge CLK);
        LD = ld; DR = dr; D_in = din; RSV = rsv; RSV_DR = rdr; CLR = clr; SA = sa; SB = sb;
        #1;
        check_comb();
        @(posedge CLK);
        mstep();
        #1;
        check_reg();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET_N = 1'b0;
        LD = 0; DR = 0; D_in = 0; RSV = 0; RSV_DR = 0; CLR = 0; SA = 0; SB = 0;
        mreset();
        #1;
        check_comb();
        check_reg();
        repeat (2) @(negedge CLK);
        RESET_N = 1'b1;

        // all addresses read zero and idle after reset
        for (int i = 0; i < 8; i++) cycle(0, 0, 0, 0, 0, 0, 3'(i), 3'(7 - i));

        // write 0xA5 to R5 while reading it, then read it back
        cycle(1, 5, 8'hA5, 0, 0, 0, 5, 5);
        cycle(0, 0, 8'h00, 0, 0, 0, 5, 5);
        chk("R5_readback", 0, 32'(da[0]), 32'h A5);
        chk("R5_readback", 1, 32'(db[1]), 32'h A5);

        // reserve R3, double-reserve it, then write it back
        cycle(0, 0, 0, 1, 3, 0, 3, 3);
        chk("NBUSY_rsv3", 0, 32'(nb[0]), 32'd1);
        cycle(0, 0, 0, 1, 3, 0, 3, 0);
        chk("RSV_ERR_dbl", 0, 32'(rerr[0]), 32'd1);
        chk("NBUSY_dbl", 0, 32'(nb[0]), 32'd1);
        cycle(1, 3, 8'h5A, 0, 0, 0, 3, 3);
        chk("RSV_ERR_drop", 0, 32'(rerr[0]), 32'd0);
        chk("NBUSY_wb3", 0, 32'(nb[0]), 32'd0);

        // writeback and reservation of R2 in the same cycle
        cycle(1, 2, 8'h3C, 1, 2, 0, 2, 2);
        chk("RSV_ERR_same", 0, 32'(rerr[0]), 32'd0);
        cycle(0, 0, 0, 0, 0, 0, 2, 2);
        chk("R2_data", 0, 32'(da[0]), 32'h3C);
        chk("R2_busy", 0, 32'(ba[0]), 32'd1);

        // writes and reservations to R0 (ignored in the zero-R0 build)
        cycle(1, 0, 8'hFF, 1, 0, 0, 0, 0);
        chk("R0_nbusy", 1, 32'(nb[1]), 32'd1);
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        chk("R0_zero", 1, 32'(da[1]), 32'h00);
        chk("R0_busy", 1, 32'(ba[1]), 32'd0);

        // reserve every register, then clear with a concurrent write
        for (int i = 0; i < 8; i++) cycle(0, 0, 0, 1, 3'(i), 0, 3'(i), 3'(7 - i));
        chk("NBUSY_full", 0, 32'(nb[0]), 32'd8);
        chk("NBUSY_full", 1, 32'(nb[1]), 32'd7);
        cycle(1, 1, 8'h99, 1, 4, 1, 1, 4);
        chk("NBUSY_clr", 0, 32'(nb[0]), 32'd0);
        cycle(0, 0, 0, 0, 0, 0, 1, 5);
        chk("R1_clr", 0, 32'(da[0]), 32'h00);

        // asynchronous reset in the middle of a write cycle
        cycle(1, 4, 8'h77, 1, 6, 0, 4, 6);
        @(negedge CLK);
        LD = 1; DR = 6; D_in = 8'h11; RSV = 1; RSV_DR = 7; CLR = 0; SA = 4; SB = 5;
        #2;
        RESET_N = 1'b0;
        #1;
        mreset();
        check_comb();
        check_reg();
        chk("async_rst_R4", 0, 32'(da[0]), 32'h00);
        @(negedge CLK);
        LD = 0; RSV = 0;
        RESET_N = 1'b1;
        cycle(0, 0, 0, 0, 0, 0, 6, 4);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            cycle(($urandom_range(0, 2) != 0), 3'($urandom), 8'($urandom),
                  ($urandom_range(0, 1) != 0), 3'($urandom),
                  ($urandom_range(0, 31) == 0), 3'($urandom), 3'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
